// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes, and
// whole-pipeline freezes for multi-cycle data-memory accesses, plus a stall counter.
module hazard_stall_controller #(
    parameter int unsigned LOAD_STALLS = 1,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [2:0]       i_rs,
    input  logic [2:0]       i_rd,
    input  logic             i_rs_used,
    input  logic             i_rd_used,
    input  logic [2:0]       i_idex_rd,
    input  logic             i_idex_mem_read,
    input  logic             i_idex_wb,
    input  logic             i_branch_taken,
    input  logic             i_mem_access,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_bubble_idex,
    output logic             o_flush_ifid,
    output logic             o_freeze,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int unsigned LD_W = (LOAD_STALLS > 1) ? $clog2(LOAD_STALLS) : 1;
    localparam int unsigned MW_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam bit FREEZE_EN = (MEM_LATENCY > 1);
    localparam bit LONG_MEM  = (MEM_LATENCY > 2);
    localparam bit MULTI_LD  = (LOAD_STALLS > 1);
    localparam logic [LD_W-1:0] LD_INIT  = LD_W'((LOAD_STALLS > 1) ? LOAD_STALLS - 1 : 0);
    localparam logic [MW_W-1:0] MEM_INIT = MW_W'((MEM_LATENCY > 2) ? MEM_LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

    state_t           r_state, w_next_state;
    state_t           r_resume, w_next_resume;
    logic [LD_W-1:0]  r_ld_cnt, w_next_ld_cnt;
    logic [MW_W-1:0]  r_mem_cnt, w_next_mem_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_load_use;
    logic w_stall;
    logic w_bubble;
    logic w_flush;
    logic w_freeze;
    logic w_any;

    assign w_load_use = i_idex_mem_read & i_idex_wb &
                        ((i_rs_used & (i_idex_rd == i_rs)) |
                         (i_rd_used & (i_idex_rd == i_rd)));

    // Next-state and control decode; freeze outranks flush, flush outranks load-use
    always_comb begin
        w_next_state   = r_state;
        w_next_resume  = r_resume;
        w_next_ld_cnt  = r_ld_cnt;
        w_next_mem_cnt = r_mem_cnt;
        w_stall        = 1'b0;
        w_bubble       = 1'b0;
        w_flush        = 1'b0;
        w_freeze       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (i_mem_access && FREEZE_EN) begin
                    w_freeze       = 1'b1;
                    w_next_mem_cnt = MEM_INIT;
                    w_next_resume  = S_RUN;
                    if (LONG_MEM) w_next_state = S_MEM_WAIT;
                end else if (i_branch_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_load_use) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (MULTI_LD) begin
                        w_next_ld_cnt = LD_INIT;
                        w_next_state  = S_LOAD_STALL;
                    end
                end
            end
            S_LOAD_STALL: begin
                if (i_mem_access && FREEZE_EN) begin
                    w_freeze       = 1'b1;
                    w_next_mem_cnt = MEM_INIT;
                    w_next_resume  = S_LOAD_STALL;
                    if (LONG_MEM) w_next_state = S_MEM_WAIT;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_ld_cnt <= LD_W'(1)) w_next_state  = S_RUN;
                    else                      w_next_ld_cnt = r_ld_cnt - LD_W'(1);
                end
            end
            S_MEM_WAIT: begin
                // The entry cycle already froze once, so leave as the count reaches 1
                w_freeze = 1'b1;
                if (r_mem_cnt <= MW_W'(1)) w_next_state   = r_resume;
                else                       w_next_mem_cnt = r_mem_cnt - MW_W'(1);
            end
            default: w_next_state = S_RUN;
        endcase
    end

    assign w_any = w_stall | w_bubble | w_flush | w_freeze;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_RUN;
            r_resume      <= S_RUN;
            r_ld_cnt      <= '0;
            r_mem_cnt     <= '0;
            r_stall_count <= '0;
        end else begin
            r_state   <= w_next_state;
            r_resume  <= w_next_resume;
            r_ld_cnt  <= w_next_ld_cnt;
            r_mem_cnt <= w_next_mem_cnt;
            if (w_any && (r_stall_count != '1)) r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign o_stall_pc    = ~i_reset & w_stall;
    assign o_stall_ifid  = ~i_reset & w_stall;
    assign o_bubble_idex = ~i_reset & w_bubble;
    assign o_flush_ifid  = ~i_reset & w_flush;
    assign o_freeze      = ~i_reset & w_freeze;
    assign o_state       = i_reset ? 2'd0 : r_state;
    assign o_stall_count = i_reset ? '0 : r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three parameterisations share one stimulus
// stream and are checked each cycle against a cycle-budget model plus literals.
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst;
    logic [2:0] rs, rd, exrd;
    logic       rsu, rdu, mr, wb, br, ma;

    logic       s_pc[3], s_if[3], s_bub[3], s_fl[3], s_fr[3];
    logic [1:0] s_st[3];
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: LS=1 ML=4; instance 1: LS=3 ML=3; instance 2: LS=1 ML=2 CNT_W=2
    hazard_stall_controller #(.LOAD_STALLS(1), .MEM_LATENCY(4), .CNT_W(16)) u_a (
        .i_clk(clk), .i_reset(rst), .i_rs(rs), .i_rd(rd), .i_rs_used(rsu), .i_rd_used(rdu),
        .i_idex_rd(exrd), .i_idex_mem_read(mr), .i_idex_wb(wb), .i_branch_taken(br),
        .i_mem_access(ma), .o_stall_pc(s_pc[0]), .o_stall_ifid(s_if[0]),
        .o_bubble_idex(s_bub[0]), .o_flush_ifid(s_fl[0]), .o_freeze(s_fr[0]),
        .o_state(s_st[0]), .o_stall_count(cnt_a));

    hazard_stall_controller #(.LOAD_STALLS(3), .MEM_LATENCY(3), .CNT_W(16)) u_b (
        .i_clk(clk), .i_reset(rst), .i_rs(rs), .i_rd(rd), .i_rs_used(rsu), .i_rd_used(rdu),
        .i_idex_rd(exrd), .i_idex_mem_read(mr), .i_idex_wb(wb), .i_branch_taken(br),
        .i_mem_access(ma), .o_stall_pc(s_pc[1]), .o_stall_ifid(s_if[1]),
        .o_bubble_idex(s_bub[1]), .o_flush_ifid(s_fl[1]), .o_freeze(s_fr[1]),
        .o_state(s_st[1]), .o_stall_count(cnt_b));

    hazard_stall_controller #(.LOAD_STALLS(1), .MEM_LATENCY(2), .CNT_W(2)) u_c (
        .i_clk(clk), .i_reset(rst), .i_rs(rs), .i_rd(rd), .i_rs_used(rsu), .i_rd_used(rdu),
        .i_idex_rd(exrd), .i_idex_mem_read(mr), .i_idex_wb(wb), .i_branch_taken(br),
        .i_mem_access(ma), .o_stall_pc(s_pc[2]), .o_stall_ifid(s_if[2]),
        .o_bubble_idex(s_bub[2]), .o_flush_ifid(s_fl[2]), .o_freeze(s_fr[2]),
        .o_state(s_st[2]), .o_stall_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int act_cnt(input int k);
        if (k == 0) return int'(cnt_a);
        if (k == 1) return int'(cnt_b);
        return int'(cnt_c);
    endfunction

    // Model: pending freeze cycles and pending load stalls, as plain budgets
    int p_ls[3]   = '{1, 3, 1};
    int p_ml[3]   = '{4, 3, 2};
    int p_cmax[3] = '{65535, 65535, 3};
    int frz_left[3]   = '{0, 0, 0};
    int stall_left[3] = '{0, 0, 0};
    int mcount[3]     = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int e_st, e_bub, e_fl, e_fr, e_state, e_cnt;
            bit lu;
            e_st = 0; e_bub = 0; e_fl = 0; e_fr = 0; e_state = 0; e_cnt = 0;
            lu = mr && wb && ((rsu && exrd == rs) || (rdu && exrd == rd));
            if (rst) begin
                frz_left[k] = 0; stall_left[k] = 0; mcount[k] = 0;
            end else begin
                e_state = (frz_left[k] > 0) ? 2 : (stall_left[k] > 0) ? 1 : 0;
                e_cnt   = mcount[k];
                if (frz_left[k] > 0) begin
                    e_fr = 1; frz_left[k]--;
                end else if (ma && p_ml[k] > 1) begin
                    e_fr = 1; frz_left[k] = p_ml[k] - 2;
                end else if (stall_left[k] > 0) begin
                    e_st = 1; e_bub = 1; stall_left[k]--;
                end else if (br) begin
                    e_fl = 1; e_bub = 1;
                end else if (lu) begin
                    e_st = 1; e_bub = 1; stall_left[k] = p_ls[k] - 1;
                end
                if ((e_st | e_bub | e_fl | e_fr) != 0 && mcount[k] < p_cmax[k]) mcount[k]++;
            end
            chk("stall_pc", k, int'(s_pc[k]), e_st);
            chk("stall_ifid", k, int'(s_if[k]), e_st);
            chk("bubble_idex", k, int'(s_bub[k]), e_bub);
            chk("flush_ifid", k, int'(s_fl[k]), e_fl);
            chk("freeze", k, int'(s_fr[k]), e_fr);
            chk("state", k, int'(s_st[k]), e_state);
            chk("stall_count", k, act_cnt(k), e_cnt);
        end
    end

    // One cycle of stimulus; returns just after the sampling edge
    task automatic step(input logic r, input logic [2:0] a_rs, input logic [2:0] a_rd,
                        input logic a_rsu, input logic a_rdu, input logic [2:0] a_exrd,
                        input logic a_mr, input logic a_wb, input logic a_br, input logic a_ma);
        @(posedge clk); #1;
        rst = r; rs = a_rs; rd = a_rd; rsu = a_rsu; rdu = a_rdu; exrd = a_exrd;
        mr = a_mr; wb = a_wb; br = a_br; ma = a_ma;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        step(0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; rs = 0; rd = 0; rsu = 0; rdu = 0; exrd = 3'd7; mr = 0; wb = 0; br = 0; ma = 0;
        repeat (2) @(posedge clk);

        step(1, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 1, 0);
        chk("lit_reset_flush", 0, int'(s_fl[0]), 0);
        chk("lit_reset_state", 0, int'(s_st[0]), 0);
        idle();
        chk("lit_count0", 0, int'(cnt_a), 0);

        step(0, 3'd3, 3'd0, 1, 0, 3'd3, 1, 1, 0, 0);
        chk("lit_lu_stall", 0, int'(s_pc[0]), 1);
        chk("lit_lu_bubble", 0, int'(s_bub[0]), 1);
        idle();
        chk("lit_lu_count", 0, int'(cnt_a), 1);
        chk("lit_lu_one_cycle", 0, int'(s_pc[0]), 0);
        step(0, 3'd3, 3'd5, 0, 1, 3'd3, 1, 1, 0, 0);
        chk("lit_rs_unused", 0, int'(s_pc[0]), 0);
        step(0, 3'd3, 3'd0, 1, 0, 3'd3, 1, 0, 0, 0);
        chk("lit_no_wb", 0, int'(s_pc[0]), 0);
        chk("lit_no_wb_count", 0, int'(cnt_a), 1);
        step(0, 3'd3, 3'd0, 1, 0, 3'd3, 1, 1, 1, 0);
        chk("lit_br_flush", 0, int'(s_fl[0]), 1);
        chk("lit_br_nostall", 0, int'(s_pc[0]), 0);
        idle();
        chk("lit_br_count", 0, int'(cnt_a), 2);

        step(0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 0, 1);
        chk("lit_frz1", 0, int'(s_fr[0]), 1);
        chk("lit_frz1_state", 0, int'(s_st[0]), 0);
        idle();
        chk("lit_frz2_state", 0, int'(s_st[0]), 2);
        idle();
        chk("lit_frz3", 0, int'(s_fr[0]), 1);
        idle();
        chk("lit_frz_end", 0, int'(s_fr[0]), 0);
        chk("lit_frz_count", 0, int'(cnt_a), 5);

        step(1, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 0, 0);
        idle();
        chk("lit_b_count0", 1, int'(cnt_b), 0);
        step(0, 3'd2, 3'd0, 1, 0, 3'd2, 1, 1, 0, 0);
        chk("lit_b_stall1", 1, int'(s_pc[1]), 1);
        step(0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 0, 1);
        chk("lit_b_frz1", 1, int'(s_fr[1]), 1);
        chk("lit_b_frz1_state", 1, int'(s_st[1]), 1);
        idle();
        chk("lit_b_frz2_state", 1, int'(s_st[1]), 2);
        idle();
        chk("lit_b_stall2", 1, int'(s_pc[1]), 1);
        idle();
        chk("lit_b_stall3_state", 1, int'(s_st[1]), 1);
        idle();
        chk("lit_b_done_state", 1, int'(s_st[1]), 0);
        chk("lit_b_total", 1, int'(cnt_b), 5);
        chk("lit_c_count2", 2, int'(cnt_c), 2);

        step(0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 1, 0);
        step(0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 1, 0);
        idle();
        chk("lit_c_saturate", 2, int'(cnt_c), 3);

        step(0, 3'd0, 3'd0, 0, 0, 3'd7, 0, 0, 0, 1);
        idle();
        chk("lit_mw_state", 0, int'(s_st[0]), 2);
        step(1, 3'd1, 3'd0, 1, 0, 3'd1, 1, 1, 1, 1);
        chk("lit_rst_freeze", 0, int'(s_fr[0]), 0);
        chk("lit_rst_count", 0, int'(cnt_a), 0);
        idle();
        chk("lit_post_rst_state", 0, int'(s_st[0]), 0);
        chk("lit_post_rst_freeze", 0, int'(s_fr[0]), 0);
        chk("lit_post_rst_count", 0, int'(cnt_a), 0);
        idle();

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
